// File: rtl/fano_branch_metric.sv
// Fano branch metric stage: circular soft-symbol window plus a 2-stage metric pipeline.
// Optional FANO_BM_ERASURE_EN stores per-bit erasure flags so punctured bits contribute nothing.
module fano_branch_metric #(
    parameter int SOFT_W = 4,
    parameter int ADDR_W = 10,
    parameter int BIAS   = 6,
    parameter int MET_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_sym_vld,
    input  logic [2*SOFT_W-1:0]     i_sym_soft,
    input  logic [1:0]              i_sym_era,
    input  logic                    i_rel_vld,
    input  logic [ADDR_W:0]         i_rel_cnt,
    input  logic                    i_rib_vld,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [1:0]              i_rib_0,
    input  logic [1:0]              i_rib_1,
    output logic                    o_vld,
    output logic signed [MET_W-1:0] o_met_0,
    output logic signed [MET_W-1:0] o_met_1,
    output logic                    o_best,
    output logic                    o_miss,
    output logic                    o_full,
    output logic                    o_ovf,
    output logic [ADDR_W:0]         o_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam int MW    = MET_W + SOFT_W + 2;
`ifdef FANO_BM_ERASURE_EN
    localparam int WORD_W = 2*SOFT_W + 2;
`else
    localparam int WORD_W = 2*SOFT_W;
`endif
    localparam logic signed [MW-1:0] SAT_MAX = MW'((1 << (MET_W-1)) - 1);
    localparam logic signed [MW-1:0] SAT_MIN = ~SAT_MAX;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] ram_q;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rel_off;
    logic [CW-1:0]     count;
    logic [CW-1:0]     rel_amt;
    logic [CW-1:0]     count_next;
    logic              push_ok;
    logic              ovf;
    logic              in_win;

    logic              s1_vld;
    logic              s1_hit;
    logic [1:0]        s1_rib_0;
    logic [1:0]        s1_rib_1;

    logic [SOFT_W-1:0]       soft_info;
    logic [SOFT_W-1:0]       soft_par;
    logic [1:0]              era;
    logic signed [MET_W-1:0] met_0_c;
    logic signed [MET_W-1:0] met_1_c;

`ifdef FANO_BM_ERASURE_EN
    assign wr_word = {i_sym_era, i_sym_soft};
    assign era     = ram_q[2*SOFT_W+1:2*SOFT_W];
`else
    logic unused_era;
    assign unused_era = ^i_sym_era;
    assign wr_word    = i_sym_soft;
    assign era        = 2'b00;
`endif

    // Releases are clamped to what is stored, so count can never underflow.
    assign push_ok    = i_sym_vld && (count < CW'(DEPTH));
    assign rel_amt    = i_rel_vld ? ((i_rel_cnt < count) ? i_rel_cnt : count) : '0;
    assign count_next = count + {{ADDR_W{1'b0}}, push_ok} - rel_amt;
    assign rel_off    = i_addr - base;
    assign in_win     = {1'b0, rel_off} < count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            base   <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (i_sym_vld && !push_ok)
                ovf <= 1'b1;
            base  <= base + rel_amt[ADDR_W-1:0];
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_word;
        ram_q <= mem[i_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_hit   <= 1'b0;
            s1_rib_0 <= '0;
            s1_rib_1 <= '0;
        end else begin
            s1_vld   <= i_rib_vld;
            s1_hit   <= in_win;
            s1_rib_0 <= i_rib_0;
            s1_rib_1 <= i_rib_1;
        end
    end

    // Distance to an expected '1' is the complement of the soft value.
    function automatic logic signed [MW-1:0] bit_term(input logic c,
                                                      input logic [SOFT_W-1:0] s,
                                                      input logic erased);
        logic [SOFT_W-1:0] d;
        d = c ? ~s : s;
        if (erased)
            bit_term = '0;
        else
            bit_term = $signed(MW'(BIAS)) - $signed({{(MW-SOFT_W){1'b0}}, d});
    endfunction

    function automatic logic signed [MET_W-1:0] saturate(input logic signed [MW-1:0] v);
        if (v > SAT_MAX)
            saturate = MET_W'(SAT_MAX);
        else if (v < SAT_MIN)
            saturate = MET_W'(SAT_MIN);
        else
            saturate = MET_W'(v);
    endfunction

    assign soft_info = ram_q[2*SOFT_W-1:SOFT_W];
    assign soft_par  = ram_q[SOFT_W-1:0];
    assign met_0_c   = saturate(bit_term(s1_rib_0[1], soft_info, era[1]) +
                                bit_term(s1_rib_0[0], soft_par,  era[0]));
    assign met_1_c   = saturate(bit_term(s1_rib_1[1], soft_info, era[1]) +
                                bit_term(s1_rib_1[0], soft_par,  era[0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            o_vld   <= 1'b0;
            o_met_0 <= '0;
            o_met_1 <= '0;
            o_best  <= 1'b0;
            o_miss  <= 1'b0;
        end else begin
            o_vld   <= s1_vld;
            o_miss  <= s1_vld && !s1_hit;
            o_met_0 <= (s1_vld && s1_hit) ? met_0_c : '0;
            o_met_1 <= (s1_vld && s1_hit) ? met_1_c : '0;
            o_best  <= s1_vld && s1_hit && (met_1_c > met_0_c);
        end
    end

    assign o_full  = (count == CW'(DEPTH));
    assign o_ovf   = ovf;
    assign o_count = count;

endmodule

// File: tb/tb_fano_branch_metric.sv
// Directed bench for fano_branch_metric: default instance plus a BIAS=100 instance for saturation.
module tb_fano_branch_metric;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              sym_vld = 1'b0;
    logic [7:0]        sym_soft = '0;
    logic [1:0]        sym_era = '0;
    logic              rel_vld = 1'b0;
    logic [10:0]       rel_cnt = '0;
    logic              rib_vld = 1'b0;
    logic [9:0]        addr = '0;
    logic [1:0]        rib_0 = '0;
    logic [1:0]        rib_1 = '0;
    logic              vld;
    logic signed [7:0] met_0;
    logic signed [7:0] met_1;
    logic              best;
    logic              miss;
    logic              full;
    logic              ovf;
    logic [10:0]       count;

    logic              s_sym_vld = 1'b0;
    logic [7:0]        s_sym_soft = '0;
    logic              s_rib_vld = 1'b0;
    logic [2:0]        s_addr = '0;
    logic [1:0]        s_rib_0 = '0;
    logic [1:0]        s_rib_1 = '0;
    logic              s_vld;
    logic signed [7:0] s_met_0;
    logic signed [7:0] s_met_1;
    logic              s_best;
    logic              s_miss;
    logic              s_full;
    logic              s_ovf;
    logic [3:0]        s_count;

    int checks = 0;
    int errors = 0;

    fano_branch_metric dut (
        .clk(clk), .reset(reset),
        .i_sym_vld(sym_vld), .i_sym_soft(sym_soft), .i_sym_era(sym_era),
        .i_rel_vld(rel_vld), .i_rel_cnt(rel_cnt),
        .i_rib_vld(rib_vld), .i_addr(addr), .i_rib_0(rib_0), .i_rib_1(rib_1),
        .o_vld(vld), .o_met_0(met_0), .o_met_1(met_1), .o_best(best),
        .o_miss(miss), .o_full(full), .o_ovf(ovf), .o_count(count)
    );

    fano_branch_metric #(.BIAS(100), .ADDR_W(3)) dut_sat (
        .clk(clk), .reset(reset),
        .i_sym_vld(s_sym_vld), .i_sym_soft(s_sym_soft), .i_sym_era(2'b00),
        .i_rel_vld(1'b0), .i_rel_cnt(4'd0),
        .i_rib_vld(s_rib_vld), .i_addr(s_addr), .i_rib_0(s_rib_0), .i_rib_1(s_rib_1),
        .o_vld(s_vld), .o_met_0(s_met_0), .o_met_1(s_met_1), .o_best(s_best),
        .o_miss(s_miss), .o_full(s_full), .o_ovf(s_ovf), .o_count(s_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_push(input logic [3:0] info, input logic [3:0] par,
                              input logic [1:0] era);
        sym_vld  = 1'b1;
        sym_soft = {info, par};
        sym_era  = era;
        step();
        sym_vld  = 1'b0;
        sym_era  = 2'b00;
    endtask

    task automatic apply_release(input logic [10:0] n);
        rel_vld = 1'b1;
        rel_cnt = n;
        step();
        rel_vld = 1'b0;
    endtask

    task automatic apply_request(input logic [9:0] a, input logic [1:0] r0, input logic [1:0] r1);
        rib_vld = 1'b1;
        addr    = a;
        rib_0   = r0;
        rib_1   = r1;
        step();
    endtask

    task automatic check_result(input string tag, input int m0, input int m1,
                                input int b, input int ms);
        check_output({tag, ".vld"}, vld, 1);
        check_output({tag, ".met0"}, met_0, m0);
        check_output({tag, ".met1"}, met_1, m1);
        check_output({tag, ".best"}, best, b);
        check_output({tag, ".miss"}, miss, ms);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        check_output("rst.vld", vld, 0);
        check_output("rst.met0", met_0, 0);
        check_output("rst.met1", met_1, 0);
        check_output("rst.best", best, 0);
        check_output("rst.miss", miss, 0);
        check_output("rst.full", full, 0);
        check_output("rst.ovf", ovf, 0);
        check_output("rst.count", count, 0);

        // Saturation: unsaturated 170 vs 200 both clamp to 127, so best must be 0
        s_sym_vld  = 1'b1;
        s_sym_soft = {4'd0, 4'd15};
        step();
        s_sym_vld  = 1'b0;
        s_rib_vld  = 1'b1;
        s_addr     = 3'd0;
        s_rib_0    = 2'b10;
        s_rib_1    = 2'b01;
        step();
        s_rib_vld  = 1'b0;
        step();
        check_output("sat.vld", s_vld, 1);
        check_output("sat.met0", s_met_0, 127);
        check_output("sat.met1", s_met_1, 127);
        check_output("sat.best", s_best, 0);
        check_output("sat.miss", s_miss, 0);
        check_output("sat.count", s_count, 1);
        check_output("sat.full", s_full, 0);
        check_output("sat.ovf", s_ovf, 0);

        // Basic metric, parity erased when the erasure feature is built in
        apply_push(4'd0, 4'd15, 2'b01);
        apply_request(10'd0, 2'b01, 2'b11);
        rib_vld = 1'b0;
        check_output("lat.vld_early", vld, 0);
        step();
`ifdef FANO_BM_ERASURE_EN
        check_result("basic", 6, -9, 0, 0);
`else
        check_result("basic", 12, -3, 0, 0);
`endif

        apply_push(4'd15, 4'd15, 2'b00);
        apply_request(10'd1, 2'b00, 2'b11);
        rib_vld = 1'b0;
        step();
        check_result("best1", -18, 12, 1, 0);

        // Five stored, then release 3 alongside a push
        apply_push(4'd7, 4'd7, 2'b00);
        apply_push(4'd3, 4'd10, 2'b00);
        apply_push(4'd8, 4'd1, 2'b00);
        check_output("fill5.count", count, 5);
        sym_vld  = 1'b1;
        sym_soft = {4'd12, 4'd4};
        rel_vld  = 1'b1;
        rel_cnt  = 11'd3;
        step();
        sym_vld  = 1'b0;
        rel_vld  = 1'b0;
        check_output("pushrel.count", count, 3);
        apply_request(10'd1, 2'b00, 2'b11);
        apply_request(10'd3, 2'b00, 2'b10);
        rib_vld = 1'b0;
        check_result("win.miss", 0, 0, 0, 1);
        step();
        check_result("win.hit", -1, -10, 0, 0);

        apply_release(11'd2047);
        check_output("relclamp.count", count, 0);
        apply_request(10'd5, 2'b00, 2'b00);
        rib_vld = 1'b0;
        step();
        check_result("empty.miss", 0, 0, 0, 1);

        // Reset with a request in flight must suppress its o_vld
        apply_push(4'd1, 4'd1, 2'b00);
        apply_request(10'd6, 2'b00, 2'b11);
        rib_vld = 1'b0;
        reset = 1'b1;
        step();
        check_output("midrst.vld", vld, 0);
        check_output("midrst.count", count, 0);
        reset = 1'b0;
        step();
        check_output("midrst.vld2", vld, 0);

        // Fill to DEPTH, then one dropped push
        for (int k = 0; k < 1023; k++)
            apply_push(4'(k), 4'(k >> 4), 2'b00);
        check_output("fill.full_early", full, 0);
        apply_push(4'd15, 4'd15, 2'b00);
        check_output("fill.full", full, 1);
        check_output("fill.ovf_early", ovf, 0);
        check_output("fill.count", count, 1024);
        apply_push(4'd15, 4'd15, 2'b00);
        check_output("ovf.ovf", ovf, 1);
        check_output("ovf.count", count, 1024);
        apply_request(10'd0, 2'b00, 2'b11);
        rib_vld = 1'b0;
        step();
        check_result("ovf.pair0", 12, -18, 0, 0);

        // Wrap-around: slot 0 reused while base moves to 2
        apply_release(11'd1);
        sym_vld  = 1'b1;
        sym_soft = {4'd5, 4'd9};
        rel_vld  = 1'b1;
        rel_cnt  = 11'd1;
        step();
        sym_vld  = 1'b0;
        rel_vld  = 1'b0;
        check_output("wrap.count", count, 1023);
        check_output("wrap.full", full, 0);
        check_output("wrap.ovf_sticky", ovf, 1);
        apply_request(10'd1023, 2'b11, 2'b00);
        apply_request(10'd0, 2'b11, 2'b00);
        check_result("wrap.top", 12, -18, 0, 0);
        apply_request(10'd1, 2'b11, 2'b00);
        rib_vld = 1'b0;
        check_result("wrap.zero", -4, -2, 1, 0);
        step();
        check_result("wrap.miss", 0, 0, 0, 1);
        step();
        check_output("idle.vld", vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
